// File: rtl/decode_stage.sv
// Instruction decode stage: decodes each accepted instruction into a one-hot
// opcode, buffers it in a 2-entry FIFO, and halts intake after an HLT drains.
module decode_stage #(
    parameter int IW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [24:0]   out_op,
    output logic [IW-1:0] out_instr,
    output logic          out_illegal,
    input  logic          flush,
    input  logic          resume,
    output logic          halted,
    output logic [CW-1:0] dec_count
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

    function automatic logic [24:0] decode_op(input logic [IW-1:0] instr);
        logic [4:0]  op5;
        logic [3:0]  cnd;
        logic [1:0]  fn;
        logic [24:0] op;
        op5 = instr[IW-1 -: 5];
        cnd = instr[IW-5 -: 4];
        fn  = instr[1:0];
        op  = 25'd0;
        case (op5)
            5'b11000: begin
                case (cnd)
                    4'b0000: op[0] = 1'b1;
                    4'b0001: op[1] = 1'b1;
                    4'b0010: op[2] = 1'b1;
                    4'b0011: op[3] = 1'b1;
                    default: op = 25'd0;
                endcase
            end
            5'b11001: begin
                if (cnd == 4'b1110) op[4] = 1'b1;
                else                op = 25'd0;
            end
            5'b00000: op[5 + 32'(fn)] = 1'b1;
            5'b00001: op[9]  = 1'b1;
            5'b00010: op[10] = 1'b1;
            5'b00011: op[11] = 1'b1;
            5'b00100: op[12] = 1'b1;
            5'b00101: op[13] = 1'b1;
            5'b00110: begin
                case (fn)
                    2'b00:   op[14] = 1'b1;
                    2'b01:   op[15] = 1'b1;
                    default: op = 25'd0;
                endcase
            end
            5'b00111: op[16] = 1'b1;
            5'b01000: op[17] = 1'b1;
            5'b01011: op[18] = 1'b1;
            5'b10000: op[19] = 1'b1;
            5'b10001: op[20] = 1'b1;
            5'b10010: op[21] = 1'b1;
            5'b10011: op[22] = 1'b1;
            5'b11100: begin
                case (fn)
                    2'b00:   op[23] = 1'b1;
                    2'b01:   op[24] = 1'b1;
                    default: op = 25'd0;
                endcase
            end
            default: op = 25'd0;
        endcase
        return op;
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      count_q, count_d;
    logic            in_ready_q, in_ready_d;
    logic [CW-1:0]   dec_count_q, dec_count_d;
    logic [IW-1:0]   head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
    logic [24:0]     head_op_q, head_op_d, tail_op_q, tail_op_d;
    logic            head_ill_q, head_ill_d, tail_ill_q, tail_ill_d;
    logic            push_s, pop_s;
    logic [24:0]     new_op_s;
    logic            new_ill_s;

    assign out_valid   = (count_q != 2'd0);
    assign push_s      = in_valid & in_ready_q;
    assign pop_s       = out_valid & out_ready;
    assign new_op_s    = decode_op(in_instr);
    assign new_ill_s   = (new_op_s == 25'd0);
    assign in_ready    = in_ready_q;
    assign out_op      = head_op_q;
    assign out_instr   = head_instr_q;
    assign out_illegal = head_ill_q;
    assign halted      = (state_q == ST_HALTED);
    assign dec_count   = dec_count_q;

    // Next-state: FIFO movement, halt sequencing, delivered-instruction count.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        dec_count_d  = dec_count_q;
        head_instr_d = head_instr_q;
        head_op_d    = head_op_q;
        head_ill_d   = head_ill_q;
        tail_instr_d = tail_instr_q;
        tail_op_d    = tail_op_q;
        tail_ill_d   = tail_ill_q;
        if (flush) begin
            // Flush overrides push, pop and resume; nothing dropped is counted.
            count_d = 2'd0;
            state_d = ST_RUN;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_instr_d = in_instr;
                        head_op_d    = new_op_s;
                        head_ill_d   = new_ill_s;
                    end else begin
                        tail_instr_d = in_instr;
                        tail_op_d    = new_op_s;
                        tail_ill_d   = new_ill_s;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_instr_d = tail_instr_q;
                    head_op_d    = tail_op_q;
                    head_ill_d   = tail_ill_q;
                    count_d      = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_instr_d = in_instr;
                        head_op_d    = new_op_s;
                        head_ill_d   = new_ill_s;
                    end else begin
                        head_instr_d = tail_instr_q;
                        head_op_d    = tail_op_q;
                        head_ill_d   = tail_ill_q;
                        tail_instr_d = in_instr;
                        tail_op_d    = new_op_s;
                        tail_ill_d   = new_ill_s;
                    end
                end
                default: count_d = count_q;
            endcase
            if (pop_s && !head_ill_q) dec_count_d = dec_count_q + CW'(1);
            else                      dec_count_d = dec_count_q;
            case (state_q)
                ST_RUN: begin
                    if (push_s && new_op_s[24]) state_d = ST_DRAIN;
                    else                        state_d = ST_RUN;
                end
                ST_DRAIN: begin
                    if (count_d == 2'd0) state_d = ST_HALTED;
                    else                 state_d = ST_DRAIN;
                end
                ST_HALTED: begin
                    if (resume) state_d = ST_RUN;
                    else        state_d = ST_HALTED;
                end
                default: state_d = ST_RUN;
            endcase
        end
        in_ready_d = (state_d == ST_RUN) && (count_d != 2'd2);
    end

    // State and FIFO registers; reset discards every buffered entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            count_q      <= 2'd0;
            in_ready_q   <= 1'b0;
            dec_count_q  <= '0;
            head_instr_q <= '0;
            head_op_q    <= 25'd0;
            head_ill_q   <= 1'b0;
            tail_instr_q <= '0;
            tail_op_q    <= 25'd0;
            tail_ill_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            dec_count_q  <= dec_count_d;
            head_instr_q <= head_instr_d;
            head_op_q    <= head_op_d;
            head_ill_q   <= head_ill_d;
            tail_instr_q <= tail_instr_d;
            tail_op_q    <= tail_op_d;
            tail_ill_q   <= tail_ill_d;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: handshake, decode table, halt/flush/reset
// behaviour, and counter wrap on a CW=2 instance sharing the same stimulus.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, flush, resume;
    logic [15:0] in_instr;
    logic        in_ready, out_valid, out_illegal, halted;
    logic [24:0] out_op;
    logic [15:0] out_instr;
    logic [15:0] dec_count;
    logic        in_ready2, out_valid2, out_illegal2, halted2;
    logic [24:0] out_op2;
    logic [15:0] out_instr2;
    logic [1:0]  dec_count2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    decode_stage #(.IW(16), .CW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_instr(out_instr), .out_illegal(out_illegal),
        .flush(flush), .resume(resume), .halted(halted), .dec_count(dec_count)
    );

    decode_stage #(.IW(16), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_instr(in_instr), .out_valid(out_valid2), .out_ready(out_ready),
        .out_op(out_op2), .out_instr(out_instr2), .out_illegal(out_illegal2),
        .flush(flush), .resume(resume), .halted(halted2), .dec_count(dec_count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] tbl_instr [29];
    int          tbl_idx   [29];
    logic [1:0]  wrap_exp  [5];

    initial begin
        tbl_instr = '{16'hC000, 16'hC100, 16'hC200, 16'hC300, 16'hCE00,
                      16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0800,
                      16'h1000, 16'h1800, 16'h2000, 16'h2800, 16'h3000,
                      16'h3001, 16'h3800, 16'h4000, 16'h5800, 16'h8000,
                      16'h8800, 16'h9000, 16'h9800, 16'hE000,
                      16'hC400, 16'hC800, 16'h3002, 16'hE002, 16'h4800};
        tbl_idx   = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                      16, 17, 18, 19, 20, 21, 22, 23, -1, -1, -1, -1, -1};
        wrap_exp  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        resume = 1'b0; in_instr = 16'h0000;
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_op", 32'(out_op), 32'd0);
        check("rst_out_illegal", 32'(out_illegal), 32'd0);
        check("rst_out_instr", 32'(out_instr), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_dec_count", 32'(dec_count), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // ADC with out_ready high: visible next cycle, counted after pop
        in_valid = 1'b1; in_instr = 16'h0001; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("adc_valid", 32'(out_valid), 32'd1);
        check("adc_op", 32'(out_op), 32'h0000_0040);
        check("adc_instr", 32'(out_instr), 32'h0001);
        tick();
        check("adc_count", 32'(dec_count), 32'd1);
        check("adc_empty", 32'(out_valid), 32'd0);

        // Fill with out_ready low; third push refused
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h4000;
        tick();
        in_instr = 16'hC100;
        tick();
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_instr = 16'h2000;
        tick();
        check("hold_instr", 32'(out_instr), 32'h4000);
        check("hold_op", 32'(out_op), 32'h0002_0000);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("second_instr", 32'(out_instr), 32'hC100);
        check("second_op", 32'(out_op), 32'h0000_0002);
        check("second_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("drained_valid", 32'(out_valid), 32'd0);
        check("order_count", 32'(dec_count), 32'd3);

        // Illegal instruction is delivered but not counted
        in_valid = 1'b1; in_instr = 16'h6800;
        tick();
        in_valid = 1'b0;
        check("ill_flag", 32'(out_illegal), 32'd1);
        check("ill_op", 32'(out_op), 32'd0);
        tick();
        check("ill_count", 32'(dec_count), 32'd3);

        // resume outside HALTED has no effect
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume_run_halted", 32'(halted), 32'd0);
        check("resume_run_ready", 32'(in_ready), 32'd1);

        // HLT: drain, refuse further input, halt, resume
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'hE001;
        tick();
        check("hlt_op", 32'(out_op), 32'h0100_0000);
        check("drain_in_ready", 32'(in_ready), 32'd0);
        in_instr = 16'h0000;
        tick();
        check("drain_refused", 32'(out_instr), 32'hE001);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("halted", 32'(halted), 32'd1);
        check("halted_in_ready", 32'(in_ready), 32'd0);
        check("halted_empty", 32'(out_valid), 32'd0);
        check("hlt_count", 32'(dec_count), 32'd4);
        out_ready = 1'b0; resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resumed_halted", 32'(halted), 32'd0);
        check("resumed_in_ready", 32'(in_ready), 32'd1);

        // Flush with two entries, push and pop attempted at the same time
        in_valid = 1'b1; in_instr = 16'h0000;
        tick();
        in_instr = 16'h0002;
        tick();
        flush = 1'b1; in_instr = 16'h0003; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_count", 32'(dec_count), 32'd4);
        check("flush_in_ready", 32'(in_ready), 32'd1);

        // Flush drops a push that would otherwise be accepted
        in_valid = 1'b1; in_instr = 16'h0001;
        tick();
        flush = 1'b1; in_instr = 16'h0002;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_push_valid", 32'(out_valid), 32'd0);

        // Decode table, one instruction at a time
        out_ready = 1'b1;
        for (int i = 0; i < 29; i++) begin
            in_valid = 1'b1; in_instr = tbl_instr[i];
            tick();
            in_valid = 1'b0;
            check($sformatf("dec_op_%04h", tbl_instr[i]), 32'(out_op),
                  (tbl_idx[i] < 0) ? 32'd0 : (32'd1 << tbl_idx[i]));
            check($sformatf("dec_ill_%04h", tbl_instr[i]), 32'(out_illegal),
                  (tbl_idx[i] < 0) ? 32'd1 : 32'd0);
            tick();
        end
        check("table_count", 32'(dec_count), 32'd28);

        // Asynchronous reset while in DRAIN
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'hE001;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_count", 32'(dec_count), 32'd0);
        check("async_rst_op", 32'(out_op), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_drain_in_ready", 32'(in_ready), 32'd1);
        check("rst_drain_halted", 32'(halted), 32'd0);

        // Counter wrap on the CW=2 instance
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = 16'h0000;
            tick();
            in_valid = 1'b0;
            tick();
            check($sformatf("wrap_%0d", i), 32'(dec_count2), 32'(wrap_exp[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
